// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants and helpers for the FFT bit-reversal reorder stage.
package fft_bitrev_reorder_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int LOG2_POINTS = 4;
    localparam int N_POINTS    = 1 << LOG2_POINTS;

    function automatic logic [31:0] bitrev(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_bank_ram.sv
// N-entry complex register bank: one write port, one combinational read port.
module reorder_bank_ram #(
    parameter int DW = fft_bitrev_reorder_pkg::DATA_WIDTH,
    parameter int AW = fft_bitrev_reorder_pkg::LOG2_POINTS
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wre_i,
    input  logic [DW-1:0] wim_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rre_o,
    output logic [DW-1:0] rim_o
);

    logic [DW-1:0] re_q [1<<AW];
    logic [DW-1:0] im_q [1<<AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            re_q[waddr_i] <= wre_i;
            im_q[waddr_i] <= wim_i;
        end
    end

    assign rre_o = re_q[raddr_i];
    assign rim_o = im_q[raddr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversal reorder buffer behind the R2SDF FFT pipeline.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH  = fft_bitrev_reorder_pkg::DATA_WIDTH,
    parameter int LOG2_POINTS = fft_bitrev_reorder_pkg::LOG2_POINTS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   di_en,
    input  logic [DATA_WIDTH-1:0]  di_re,
    input  logic [DATA_WIDTH-1:0]  di_im,
    output logic                   do_valid,
    input  logic                   do_ready,
    output logic [DATA_WIDTH-1:0]  do_re,
    output logic [DATA_WIDTH-1:0]  do_im,
    output logic [LOG2_POINTS-1:0] do_index,
    output logic                   do_last,
    output logic                   frame_drop,
    output logic                   frame_err
);

    import fft_bitrev_reorder_pkg::*;

    localparam int N = 1 << LOG2_POINTS;
    localparam logic [LOG2_POINTS-1:0] CNT_MAX = LOG2_POINTS'(N - 1);

    logic [1:0]             full_q, full_d;
    logic                   wr_bank_q, wr_bank_d;
    logic                   wr_drop_q, wr_drop_d;
    logic [LOG2_POINTS-1:0] wr_cnt_q, wr_cnt_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [LOG2_POINTS-1:0] rd_cnt_q, rd_cnt_d;
    logic                   frame_drop_q, frame_drop_d;
    logic                   frame_err_q, frame_err_d;

    logic                   wr_start, wr_end, bank_ok, drop_now, wr_en;
    logic                   rd_fire, rd_free;
    logic [LOG2_POINTS-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]  rd_re [2];
    logic [DATA_WIDTH-1:0]  rd_im [2];

    assign wr_start = di_en && (wr_cnt_q == '0);
    assign wr_end   = di_en && (wr_cnt_q == CNT_MAX);
    assign rd_fire  = do_valid && do_ready;
    assign rd_free  = rd_fire && (rd_cnt_q == CNT_MAX);

    // A bank drained on this very edge may be refilled starting this edge.
    assign bank_ok  = !full_q[wr_bank_q] ||
                      (rd_free && (rd_bank_q == wr_bank_q));
    assign drop_now = wr_start ? !bank_ok : wr_drop_q;
    assign wr_en    = di_en && !drop_now;
    assign wr_addr  = LOG2_POINTS'(bitrev(32'(wr_cnt_q), LOG2_POINTS));

    always_comb begin
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        wr_drop_d    = 1'b0;
        wr_cnt_d     = '0;
        rd_bank_d    = rd_bank_q;
        rd_cnt_d     = rd_cnt_q;
        frame_drop_d = 1'b0;
        frame_err_d  = !di_en && (wr_cnt_q != '0);

        if (di_en) begin
            wr_cnt_d  = wr_cnt_q + 1'b1;
            wr_drop_d = wr_end ? 1'b0 : drop_now;
        end

        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (rd_free) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (wr_end) begin
            if (drop_now) begin
                frame_drop_d = 1'b1;
            end else begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            wr_drop_q    <= 1'b0;
            wr_cnt_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            frame_drop_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            wr_drop_q    <= wr_drop_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            frame_drop_q <= frame_drop_d;
            frame_err_q  <= frame_err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        reorder_bank_ram #(
            .DW (DATA_WIDTH),
            .AW (LOG2_POINTS)
        ) u_ram (
            .clk     (clk),
            .we_i    (wr_en && (wr_bank_q == 1'(b))),
            .waddr_i (wr_addr),
            .wre_i   (di_re),
            .wim_i   (di_im),
            .raddr_i (rd_cnt_q),
            .rre_o   (rd_re[b]),
            .rim_o   (rd_im[b])
        );
    end

    assign do_valid   = full_q[rd_bank_q];
    assign do_re      = do_valid ? rd_re[rd_bank_q] : '0;
    assign do_im      = do_valid ? rd_im[rd_bank_q] : '0;
    assign do_index   = rd_cnt_q;
    assign do_last    = do_valid && (rd_cnt_q == CNT_MAX);
    assign frame_drop = frame_drop_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: reorder, backpressure, drop, error, reset.
module tb_fft_bitrev_reorder;

    localparam int DW = 16;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          di_en;
    logic [DW-1:0] di_re;
    logic [DW-1:0] di_im;
    logic          do_valid;
    logic          do_ready;
    logic [DW-1:0] do_re;
    logic [DW-1:0] do_im;
    logic [LW-1:0] do_index;
    logic          do_last;
    logic          frame_drop;
    logic          frame_err;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_xfer = 0;
    int n_drop = 0;
    int n_ferr = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    fft_bitrev_reorder #(
        .DATA_WIDTH  (DW),
        .LOG2_POINTS (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .di_en      (di_en),
        .di_re      (di_re),
        .di_im      (di_im),
        .do_valid   (do_valid),
        .do_ready   (do_ready),
        .do_re      (do_re),
        .do_im      (do_im),
        .do_index   (do_index),
        .do_last    (do_last),
        .frame_drop (frame_drop),
        .frame_err  (frame_err)
    );

    function automatic logic [3:0] rev4(input logic [3:0] k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observe the cycle before the edge: a transfer happens at that edge.
    task automatic monitor();
        int          v;
        logic [15:0] er, ei;
        if (do_valid && do_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 32'(do_valid), 32'd0);
            end else begin
                v  = exp_q.pop_front();
                er = 16'(v);
                ei = 16'(-v);
                chk("re", 32'(do_re), 32'(er));
                chk("im", 32'(do_im), 32'(ei));
                chk("index", 32'(do_index), 32'(v % 16));
                chk("last", 32'(do_last), 32'((v % 16) == 15));
            end
        end
        if (!do_valid) begin
            chk("re_idle", 32'(do_re), 32'd0);
            chk("im_idle", 32'(do_im), 32'd0);
            chk("last_idle", 32'(do_last), 32'd0);
        end
        if (frame_drop) n_drop++;
        if (frame_err)  n_ferr++;
    endtask

    task automatic tick();
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input int f, input int k);
        int v;
        v     = 16 * f + int'(rev4(4'(k)));
        di_en = 1'b1;
        di_re = 16'(v);
        di_im = 16'(-v);
        tick();
    endtask

    task automatic send_frame(input int f, input int len);
        for (int k = 0; k < len; k++) send_sample(f, k);
    endtask

    task automatic push_frame(input int f);
        for (int j = 0; j < 16; j++) exp_q.push_back(16 * f + j);
    endtask

    task automatic idle(input int n);
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
        repeat (n) tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        di_en    = 1'b0;
        di_re    = '0;
        di_im    = '0;
        do_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(do_valid), 32'd0);
        chk("rst_last", 32'(do_last), 32'd0);
        chk("rst_index", 32'(do_index), 32'd0);
        chk("rst_re", 32'(do_re), 32'd0);
        chk("rst_im", 32'(do_im), 32'd0);
        chk("rst_drop", 32'(frame_drop), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        rst      = 1'b0;
        do_ready = 1'b1;

        // single frame, one-cycle latency
        n_xfer = 0;
        push_frame(0);
        send_frame(0, 15);
        chk("t1_valid_early", 32'(do_valid), 32'd0);
        send_sample(0, 15);
        chk("t1_valid_first", 32'(do_valid), 32'd1);
        chk("t1_first_idx", 32'(do_index), 32'd0);
        idle(20);
        chk("t1_left", 32'(exp_q.size()), 32'd0);
        chk("t1_xfer", 32'(n_xfer), 32'd16);

        // four frames back-to-back, gap-free
        n_xfer = 0;
        n_drop = 0;
        for (int f = 1; f <= 4; f++) push_frame(f);
        for (int f = 1; f <= 4; f++) send_frame(f, 16);
        chk("t2_xfer_mid", 32'(n_xfer), 32'd48);
        idle(16);
        chk("t2_xfer_end", 32'(n_xfer), 32'd64);
        idle(4);
        chk("t2_left", 32'(exp_q.size()), 32'd0);
        chk("t2_drop", 32'(n_drop), 32'd0);

        // backpressure: third frame dropped
        n_xfer   = 0;
        n_drop   = 0;
        do_ready = 1'b0;
        push_frame(10);
        push_frame(11);
        send_frame(10, 16);
        send_frame(11, 16);
        send_frame(12, 16);
        idle(2);
        chk("t3_drop", 32'(n_drop), 32'd1);
        chk("t3_valid_held", 32'(do_valid), 32'd1);
        chk("t3_re_held", 32'(do_re), 32'd160);
        do_ready = 1'b1;
        idle(40);
        chk("t3_xfer", 32'(n_xfer), 32'd32);
        chk("t3_left", 32'(exp_q.size()), 32'd0);
        chk("t3_drop_end", 32'(n_drop), 32'd1);

        // short frame then full frame
        pulse_rst();
        n_xfer = 0;
        n_ferr = 0;
        send_frame(20, 5);
        idle(3);
        chk("t4_err", 32'(n_ferr), 32'd1);
        chk("t4_xfer0", 32'(n_xfer), 32'd0);
        chk("t4_valid", 32'(do_valid), 32'd0);
        push_frame(21);
        send_frame(21, 16);
        idle(20);
        chk("t4_left", 32'(exp_q.size()), 32'd0);
        chk("t4_xfer", 32'(n_xfer), 32'd16);
        chk("t4_err_end", 32'(n_ferr), 32'd1);

        // bank 0 freed on the same edge a new frame starts into it
        pulse_rst();
        n_xfer   = 0;
        n_drop   = 0;
        do_ready = 1'b0;
        push_frame(30);
        push_frame(31);
        push_frame(32);
        send_frame(30, 16);
        send_frame(31, 16);
        do_ready = 1'b1;
        idle(15);
        send_frame(32, 16);
        idle(40);
        chk("t5_drop", 32'(n_drop), 32'd0);
        chk("t5_left", 32'(exp_q.size()), 32'd0);
        chk("t5_xfer", 32'(n_xfer), 32'd48);

        // reset while reading a full bank and writing a partial frame
        do_ready = 1'b0;
        push_frame(40);
        send_frame(40, 16);
        do_ready = 1'b1;
        send_frame(41, 6);
        rst = 1'b1;
        send_sample(41, 6);
        chk("t6_valid", 32'(do_valid), 32'd0);
        chk("t6_re", 32'(do_re), 32'd0);
        chk("t6_im", 32'(do_im), 32'd0);
        chk("t6_index", 32'(do_index), 32'd0);
        chk("t6_last", 32'(do_last), 32'd0);
        chk("t6_pending", 32'(exp_q.size()), 32'd9);
        exp_q.delete();
        rst    = 1'b0;
        n_xfer = 0;
        idle(5);
        chk("t6_quiet", 32'(n_xfer), 32'd0);
        chk("t6_valid_q", 32'(do_valid), 32'd0);
        push_frame(42);
        send_frame(42, 16);
        idle(20);
        chk("t6_left", 32'(exp_q.size()), 32'd0);
        chk("t6_xfer", 32'(n_xfer), 32'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
